regex_cpu_ext: RTL and testbench

Single-thread regex execution unit: accepts a `(pc, cc_id)` pair, fetches one instruction over a valid/ready memory port, executes it against the character of the addressed character-column, and emits zero, one or two successor `(pc, cc_id)` pairs or an accept pulse. It is the parametrised successor of `regex_cpu`, with the full opcode set from `instruction_package` (MATCH, NOT_MATCH, MATCH_ANY, JMP, SPLIT, ACCEPT, ACCEPT_PARTIAL, END_WITHOUT_ACCEPTING) and two-output SPLIT. It sits between the engine's PC FIFOs and the shared instruction memory arbiter.

---
 rtl/instruction_package.sv | 25 ++
 rtl/regex_cpu_exec_unit.sv | 62 ++++++
 rtl/regex_cpu_ext.sv | 125 ++++++++++++
 tb/tb_regex_cpu_ext.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_package.sv
// Shared instruction encoding for the regex engine plus the execution-unit state enum.
package instruction_package;
  localparam int INSTRUCTION_TYPE_BITS  = 3;
  localparam int INSTRUCTION_DATA_WIDTH = 13;

  typedef enum logic [INSTRUCTION_TYPE_BITS-1:0] {
    ACCEPT                = 3'd0,
    SPLIT                 = 3'd1,
    MATCH                 = 3'd2,
    JMP                   = 3'd3,
    END_WITHOUT_ACCEPTING = 3'd4,
    MATCH_ANY             = 3'd5,
    ACCEPT_PARTIAL        = 3'd6,
    NOT_MATCH             = 3'd7
  } instruction_type_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    EXEC,
    OUT_FIRST,
    OUT_SECOND
  } regex_cpu_state_t;
endpackage

// File: rtl/regex_cpu_exec_unit.sv
// Combinational decode/execute of one regex instruction against one character.
module regex_cpu_exec_unit
  import instruction_package::*;
#(
  parameter int PC_WIDTH        = 9,
  parameter int CC_ID_BITS      = 2,
  parameter int CHARACTER_WIDTH = 8,
  parameter int MEMORY_WIDTH    = 16
) (
  input  logic [MEMORY_WIDTH-1:0]    instr,
  input  logic [PC_WIDTH-1:0]        pc,
  input  logic [CC_ID_BITS-1:0]      cc_id,
  input  logic [CHARACTER_WIDTH-1:0] c,
  input  logic                       eos,
  output logic [1:0]                 emit_count,
  output logic [PC_WIDTH-1:0]        pc0,
  output logic [CC_ID_BITS-1:0]      cc0,
  output logic [PC_WIDTH-1:0]        pc1,
  output logic [CC_ID_BITS-1:0]      cc1,
  output logic                       accept
);
  instruction_type_t                 w_op;
  logic [INSTRUCTION_DATA_WIDTH-1:0] w_operand;
  logic [PC_WIDTH-1:0]               w_pc_inc;
  logic [PC_WIDTH-1:0]               w_jmp;
  logic [CHARACTER_WIDTH-1:0]        w_chr;
  logic [CC_ID_BITS-1:0]             w_nxt_cc;

  assign w_op      = instruction_type_t'(instr[MEMORY_WIDTH-1 -: INSTRUCTION_TYPE_BITS]);
  assign w_operand = instr[MEMORY_WIDTH-INSTRUCTION_TYPE_BITS-1 -: INSTRUCTION_DATA_WIDTH];
  // Operand truncation gives the jump target and the literal character.
  assign w_jmp     = PC_WIDTH'(w_operand);
  assign w_chr     = CHARACTER_WIDTH'(w_operand);
  assign w_pc_inc  = pc + PC_WIDTH'(1);
  assign w_nxt_cc  = cc_id + CC_ID_BITS'(1);

  always_comb begin
    emit_count = 2'd0;
    pc0        = w_pc_inc;
    cc0        = w_nxt_cc;
    pc1        = w_jmp;
    cc1        = cc_id;
    accept     = 1'b0;
    case (w_op)
      MATCH:     if (!eos && c == w_chr) emit_count = 2'd1;
      NOT_MATCH: if (!eos && c != w_chr) emit_count = 2'd1;
      MATCH_ANY: if (!eos) emit_count = 2'd1;
      JMP: begin
        emit_count = 2'd1;
        pc0        = w_jmp;
        cc0        = cc_id;
      end
      SPLIT: begin
        emit_count = 2'd2;
        cc0        = cc_id;
      end
      ACCEPT:         accept = eos;
      ACCEPT_PARTIAL: accept = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/regex_cpu_ext.sv
// Single-thread regex execution unit: fetch one instruction, execute it, emit successors.
module regex_cpu_ext
  import instruction_package::*;
#(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
  input  logic [2**CC_ID_BITS-1:0]                    end_of_string,
  input  logic                                        input_pc_valid,
  output logic                                        input_pc_ready,
  input  logic [PC_WIDTH-1:0]                         input_pc,
  input  logic [CC_ID_BITS-1:0]                       input_cc_id,
  output logic                                        memory_valid,
  input  logic                                        memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                     memory_data,
  output logic                                        output_pc_valid,
  input  logic                                        output_pc_ready,
  output logic [PC_WIDTH-1:0]                         output_pc,
  output logic [CC_ID_BITS-1:0]                       output_cc_id,
  output logic                                        accepts
);
  regex_cpu_state_t          r_state, w_next;
  logic [PC_WIDTH-1:0]       r_pc, r_out_pc, r_pc2;
  logic [CC_ID_BITS-1:0]     r_cc, r_out_cc, r_cc2;
  logic [MEMORY_WIDTH-1:0]   r_instr;
  logic                      r_two, r_acc;

  logic [CHARACTER_WIDTH-1:0] w_c;
  logic                       w_eos;
  logic [1:0]                 w_emit_count;
  logic [PC_WIDTH-1:0]        w_pc0, w_pc1;
  logic [CC_ID_BITS-1:0]      w_cc0, w_cc1;
  logic                       w_accept;

  assign w_c   = current_characters[r_cc*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign w_eos = end_of_string[r_cc];

  regex_cpu_exec_unit #(
    .PC_WIDTH        (PC_WIDTH),
    .CC_ID_BITS      (CC_ID_BITS),
    .CHARACTER_WIDTH (CHARACTER_WIDTH),
    .MEMORY_WIDTH    (MEMORY_WIDTH)
  ) u_exec (
    .instr      (r_instr),
    .pc         (r_pc),
    .cc_id      (r_cc),
    .c          (w_c),
    .eos        (w_eos),
    .emit_count (w_emit_count),
    .pc0        (w_pc0),
    .cc0        (w_cc0),
    .pc1        (w_pc1),
    .cc1        (w_cc1),
    .accept     (w_accept)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (input_pc_valid) w_next = FETCH;
      FETCH:      if (memory_ready) w_next = WAIT_DATA;
      WAIT_DATA:  w_next = EXEC;
      EXEC:       w_next = (w_emit_count != 2'd0) ? OUT_FIRST : IDLE;
      OUT_FIRST:  if (output_pc_ready) w_next = r_two ? OUT_SECOND : IDLE;
      OUT_SECOND: if (output_pc_ready) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_cc     <= '0;
      r_instr  <= '0;
      r_out_pc <= '0;
      r_out_cc <= '0;
      r_pc2    <= '0;
      r_cc2    <= '0;
      r_two    <= 1'b0;
      r_acc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_acc   <= 1'b0;
      case (r_state)
        IDLE: if (input_pc_valid) begin
          r_pc <= input_pc;
          r_cc <= input_cc_id;
        end
        WAIT_DATA: r_instr <= memory_data;
        EXEC: begin
          r_acc <= w_accept;
          if (w_emit_count != 2'd0) begin
            r_out_pc <= w_pc0;
            r_out_cc <= w_cc0;
            r_pc2    <= w_pc1;
            r_cc2    <= w_cc1;
            r_two    <= (w_emit_count == 2'd2);
          end
        end
        // Second SPLIT successor is loaded as the first is consumed.
        OUT_FIRST: if (output_pc_ready && r_two) begin
          r_out_pc <= r_pc2;
          r_out_cc <= r_cc2;
        end
        default: ;
      endcase
    end
  end

  assign input_pc_ready  = (r_state == IDLE) && !rst;
  assign memory_valid    = (r_state == FETCH);
  assign memory_addr     = MEMORY_ADDR_WIDTH'(r_pc);
  assign output_pc_valid = (r_state == OUT_FIRST) || (r_state == OUT_SECOND);
  assign output_pc       = r_out_pc;
  assign output_cc_id    = r_out_cc;
  assign accepts         = r_acc;
endmodule

// File: tb/tb_regex_cpu_ext.sv
// Randomised bench for regex_cpu_ext with a queue-based reference model of expected outputs.
module tb_regex_cpu_ext;
  import instruction_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_characters;
  logic [3:0]  end_of_string;
  logic        input_pc_valid, input_pc_ready;
  logic [8:0]  input_pc;
  logic [1:0]  input_cc_id;
  logic        memory_valid, memory_ready;
  logic [10:0] memory_addr;
  logic [15:0] memory_data;
  logic        output_pc_valid, output_pc_ready;
  logic [8:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        accepts;

  always #5 clk = ~clk;

  regex_cpu_ext dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready),
    .input_pc(input_pc), .input_cc_id(input_cc_id),
    .memory_valid(memory_valid), .memory_ready(memory_ready),
    .memory_addr(memory_addr), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_pc_ready(output_pc_ready),
    .output_pc(output_pc), .output_cc_id(output_cc_id), .accepts(accepts)
  );

  typedef struct {bit is_acc; int pc; int cc;} exp_t;
  exp_t expq[$];
  int   stallq[$];
  int   cur_stall = -1;
  int   exp_addr = 0;
  int   vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input instruction_type_t op, input int opnd);
    return {op, 13'(opnd)};
  endfunction

  // Successors of one instruction straight from the opcode rules.
  function automatic void model(input int pc, input int cc, input logic [15:0] ins,
                                input logic [31:0] chars, input logic [3:0] eos,
                                output int n, output int p0, output int c0,
                                output int p1, output int c1, output bit acc);
    instruction_type_t op = instruction_type_t'(ins[15:13]);
    int  opnd = int'(ins[12:0]);
    int  ch   = int'((chars >> (8 * cc)) & 32'hFF);
    bit  e    = eos[cc];
    n = 0; acc = 0; p0 = 0; c0 = 0; p1 = 0; c1 = 0;
    case (op)
      MATCH:     if (!e && ch == (opnd % 256)) begin n = 1; p0 = (pc + 1) % 512; c0 = (cc + 1) % 4; end
      NOT_MATCH: if (!e && ch != (opnd % 256)) begin n = 1; p0 = (pc + 1) % 512; c0 = (cc + 1) % 4; end
      MATCH_ANY: if (!e) begin n = 1; p0 = (pc + 1) % 512; c0 = (cc + 1) % 4; end
      JMP:       begin n = 1; p0 = opnd % 512; c0 = cc; end
      SPLIT:     begin n = 2; p0 = (pc + 1) % 512; c0 = cc; p1 = opnd % 512; c1 = cc; end
      ACCEPT:    acc = e;
      ACCEPT_PARTIAL: acc = 1;
      default: ;
    endcase
  endfunction

  // Output-side backpressure: stall each emitted pair by its queued number of cycles.
  initial begin
    output_pc_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (output_pc_valid) begin
        if (cur_stall < 0) cur_stall = (stallq.size() != 0) ? stallq.pop_front() : 0;
        if (cur_stall > 0) begin output_pc_ready = 1'b0; cur_stall--; end
        else begin output_pc_ready = 1'b1; cur_stall = -1; end
      end else begin
        output_pc_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Single compare process: every cycle with meaningful outputs is checked against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (output_pc_valid) begin
          if (expq.size() == 0 || expq[0].is_acc) chk("unexpected_out", output_pc_valid, 0);
          else begin
            chk("out_pc", output_pc, expq[0].pc);
            chk("out_cc", output_cc_id, expq[0].cc);
            if (output_pc_ready) void'(expq.pop_front());
          end
        end
        if (accepts) begin
          if (expq.size() == 0 || !expq[0].is_acc) chk("unexpected_accept", accepts, 0);
          else begin
            chk("accept", accepts, 1);
            void'(expq.pop_front());
          end
        end
        if (memory_valid) chk("mem_addr", memory_addr, exp_addr);
      end
    end
  end

  task automatic post_reset();
    @(negedge clk);
    expq.delete(); stallq.delete(); cur_stall = -1;
    chk("rst_mem_valid", memory_valid, 0);
    chk("rst_out_valid", output_pc_valid, 0);
    chk("rst_accepts", accepts, 0);
    chk("rst_mem_addr", memory_addr, 0);
    chk("rst_out_pc", output_pc, 0);
    chk("rst_out_cc", output_cc_id, 0);
    chk("rst_in_ready", input_pc_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", {memory_valid, output_pc_valid, accepts}, 0);
    end
    memory_data = 16'($urandom);
  endtask

  // rst_at: 0 none, 1 during WAIT_DATA, 2 during a stalled OUT_FIRST.
  task automatic run_txn(input int pc, input int cc, input logic [15:0] ins,
                         input logic [31:0] chars, input logic [3:0] eos,
                         input int mdel, input int st0, input int st1, input int rst_at);
    int n, p0, c0, p1, c1, t;
    bit acc;
    exp_t e;
    model(pc, cc, ins, chars, eos, n, p0, c0, p1, c1, acc);
    if (n > 0) begin e.is_acc = 0; e.pc = p0; e.cc = c0; expq.push_back(e); stallq.push_back(st0); end
    if (n > 1) begin e.is_acc = 0; e.pc = p1; e.cc = c1; expq.push_back(e); stallq.push_back(st1); end
    if (acc)   begin e.is_acc = 1; e.pc = 0;  e.cc = 0;  expq.push_back(e); end
    exp_addr = pc;
    @(posedge clk); #1;
    input_pc_valid = 1'b1; input_pc = 9'(pc); input_cc_id = 2'(cc);
    t = 0;
    @(negedge clk);
    while (!input_pc_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready", input_pc_ready, 1);
    @(posedge clk); #1;
    input_pc_valid = 1'b0; input_pc = 9'($urandom); input_cc_id = 2'($urandom);
    @(negedge clk);
    chk("fetch_valid", memory_valid, 1);
    chk("busy_not_ready", input_pc_ready, 0);
    repeat (mdel) @(negedge clk);
    chk("fetch_hold", memory_valid, 1);
    memory_ready = 1'b1;
    @(posedge clk); #1;
    memory_ready = 1'b0; memory_data = ins;
    if (rst_at == 1) rst = 1'b1;
    @(negedge clk);
    chk("fetch_done", memory_valid, 0);
    @(posedge clk); #1;
    if (rst_at == 1) begin rst = 1'b0; post_reset(); return; end
    memory_data = 16'($urandom); current_characters = chars; end_of_string = eos;
    @(posedge clk); #1;
    current_characters = $urandom; end_of_string = 4'($urandom);
    @(negedge clk);
    chk("latency", output_pc_valid | accepts, (n > 0) || acc);
    if (rst_at == 2) begin
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      post_reset();
      return;
    end
    if (n == 2 && st0 == 0 && st1 == 0) begin
      @(negedge clk);
      chk("split_b2b", output_pc_valid, 1);
    end
    t = 0;
    while (expq.size() != 0 && t < 60) begin @(negedge clk); t++; end
    if (expq.size() != 0) begin chk("drain", expq.size(), 0); expq.delete(); stallq.delete(); end
    @(negedge clk);
    chk("back_idle", input_pc_ready, 1);
  endtask

  initial begin
    int n, p0, c0, p1, c1, pc, cc, opnd;
    bit acc;
    logic [31:0] chars;
    instruction_type_t op;

    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n, p0, c0, p1, c1, pc, cc, opnd;
    bit acc;
    logic [31:0] chars;
    instruction_type_t op;

    rst = 1'b1; input_pc_valid = 1'b0; input_pc = '0; input_cc_id = '0;
    memory_ready = 1'b0; memory_data = '0;
    current_characters = $urandom; end_of_string = '0;

    // Literal pins for the model.
    model(9'h062, 3, mk(MATCH, 8'h41), 32'h41_5A_5A_5A, 4'b0000, n, p0, c0, p1, c1, acc);
    chk("pin_match_n", n, 1); chk("pin_match_pc", p0, 32'h63); chk("pin_match_cc", c0, 0);
    model(9'h062, 3, mk(MATCH, 8'h42), 32'h41_5A_5A_5A, 4'b0000, n, p0, c0, p1, c1, acc);
    chk("pin_miss_n", n, 0);
    model(9'h1FF, 1, mk(SPLIT, 13'h10), 32'h0, 4'b0000, n, p0, c0, p1, c1, acc);
    chk("pin_split_p0", p0, 0); chk("pin_split_p1", p1, 32'h10); chk("pin_split_c1", c1, 1);
    model(9'h005, 2, mk(ACCEPT, 0), 32'h0, 4'b0100, n, p0, c0, p1, c1, acc);
    chk("pin_accept", acc, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_ready", input_pc_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    post_reset();

    run_txn(9'h062, 3, mk(MATCH, 8'h41), 32'h41_5A_5A_5A, 4'b0000, 0, 0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      chk("quiet_valid", output_pc_valid, 0);
      chk("quiet_ready", input_pc_ready, 1);
    end
    run_txn(9'h062, 3, mk(MATCH, 8'h42), 32'h41_5A_5A_5A, 4'b0000, 1, 0, 0, 0);
    run_txn(9'h062, 3, mk(MATCH, 8'h41), 32'h41_5A_5A_5A, 4'b1000, 0, 0, 0, 0);
    run_txn(9'h1FF, 1, mk(SPLIT, 13'h10), $urandom, 4'b0000, 0, 5, 0, 0);
    run_txn(9'h010, 0, mk(SPLIT, 13'h1ABC), $urandom, 4'b0000, 0, 0, 0, 0);
    run_txn(9'h005, 2, mk(ACCEPT, 0), $urandom, 4'b0100, 0, 0, 0, 0);
    run_txn(9'h005, 2, mk(ACCEPT, 0), $urandom, 4'b0000, 0, 0, 0, 0);
    run_txn(9'h0AB, 0, mk(JMP, 13'h1F5), $urandom, 4'b0000, 7, 0, 0, 0);
    run_txn(9'h0C0, 1, mk(JMP, 13'h022), $urandom, 4'b0000, 0, 0, 0, 1);
    run_txn(9'h0C1, 2, mk(JMP, 13'h033), $urandom, 4'b0000, 0, 20, 0, 2);
    run_txn(9'h033, 2, mk(JMP, 13'h155), $urandom, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      op    = instruction_type_t'($urandom_range(0, 7));
      chars = $urandom;
      cc    = $urandom_range(0, 3);
      pc    = ($urandom_range(0, 7) == 0) ? 511 : $urandom_range(0, 511);
      opnd  = $urandom_range(0, 8191);
      if ($urandom_range(0, 1) == 1) opnd = (opnd & ~255) | int'((chars >> (8 * cc)) & 32'hFF);
      run_txn(pc, cc, mk(op, opnd), chars, 4'($urandom) & 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
